jk_latch_writer: RTL and testbench
==================================

// Module: jk_latch_writer
// PURPOSE
//   Write-side controller for a bank of level-sensitive JK latches. Accepts a target word via a
//   valid/ready request, derives per-bit J/K excitation from the latch bank's current Q, pulses the
//   bank enable, waits for settling, and reads Q back to verify. Retries on mismatch, then flags error.
//   Sits between a register-write master and an external jk_latch bank; never emits J=K=1.
// PARAMETERS
//   WIDTH          8  number of latches in the bank
//   SETTLE_CYCLES  2  clk cycles Q is allowed to settle after enable pulse (excl. sync delay), >=1
//   MAX_RETRY      3  re-pulse attempts after first mismatch before err; 0 = no retry
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req_valid  in   1      target word valid
//   req_ready  out  1      high only in IDLE; transfer on req_valid & req_ready
//   req_data   in   WIDTH  target Q value, captured at transfer
//   q_in       in   WIDTH  readback from latch bank Q (asynchronous to clk)
//   j_out      out  WIDTH  J drive to latch bank (registered)
//   k_out      out  WIDTH  K drive to latch bank (registered)
//   latch_en   out  1      latch bank enable (registered), one-cycle pulse
//   done       out  1      one-cycle pulse: bank verified equal to target
//   err        out  1      one-cycle pulse: retries exhausted, bank != target
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, j_out=k_out=0, latch_en=0, done=err=0, req_ready=1,
//     counters 0, synchronizer flops 0. Latch bank contents are not touched. Reset mid-operation
//     aborts immediately: latch_en drops asynchronously, no done/err is produced.
//   q_in passes through a 2-flop synchronizer; qs = synchronized value (2-cycle latency).
//   Excitation per bit (q=qs bit, t=target bit): q==t -> J=0,K=0; t=1,q=0 -> J=1,K=0;
//     t=0,q=1 -> J=0,K=1. J=K=1 (toggle) is illegal: oscillates in a level-sensitive latch.
//   FSM:
//     IDLE    req_ready=1. On transfer: capture target, retry=0 -> COMPUTE.
//     COMPUTE register j_out/k_out from qs vs target. If qs==target -> VERIFY (no pulse);
//             else -> PULSE.
//     PULSE   latch_en=1 for exactly one cycle; j_out/k_out held (set up one cycle earlier) -> SETTLE.
//     SETTLE  j_out=k_out=0, latch_en=0; stay SETTLE_CYCLES+2 cycles (covers sync delay) -> VERIFY.
//     VERIFY  qs==target: done=1 -> IDLE. Mismatch & retry<MAX_RETRY: retry++ -> COMPUTE.
//             Mismatch & retry==MAX_RETRY: err=1 -> IDLE.
//   Latency (transfer at edge ending cycle 0): COMPUTE cycle 1, PULSE cycle 2,
//     done in cycle SETTLE_CYCLES+5 (7 at defaults); no-change request: done in cycle 2.
//   Each retry adds SETTLE_CYCLES+4 cycles. Total pulses on persistent mismatch = MAX_RETRY+1.
//   req_valid while busy: ignored (req_ready=0); requester holds data. Back-to-back: next transfer
//     no earlier than the cycle after done/err (IDLE cycle). done and err never both high.
//   Widths: retry counter $clog2(MAX_RETRY+1) (min 1), settle counter $clog2(SETTLE_CYCLES+3).
//   j_out & k_out == 0 in every cycle (bitwise) -- invariant.
// STRUCTURE
//   Package jk_pkg: state enum typedef (IDLE, COMPUTE, PULSE, SETTLE, VERIFY); 2-bit excitation
//     constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10; function jk_excite(q,t) -> {J,K}.
//   Sub-module jk_sync2: WIDTH-parameterized 2-flop synchronizer, async active-low reset to 0.
//   Top: FSM, target register, counters, registered outputs.
// TESTING
//   Bench models WIDTH jk_latch bits driven by j_out/k_out/latch_en, with optional stuck-at faults.
//   1 Reset: rst_n=0 -> j_out=k_out=0, latch_en=done=err=0, req_ready=1; bank Q unchanged.
//   2 Set-only: Q=8'h00, req 8'hA5 -> j_out=8'hA5,k_out=8'h00 cycles 1-2, latch_en=1 cycle 2 only,
//     Q=8'hA5, done=1 cycle 7, err=0.
//   3 Mixed: Q=8'hF0, req 8'h0F -> j_out=8'h0F, k_out=8'hF0; assert j_out&k_out==0 throughout; done.
//   4 No-change: Q=8'h3C, req 8'h3C -> latch_en never asserted, done=1 cycle 2.
//   5 Stuck bit0 at 0, Q=8'h00, req 8'h01 -> 4 latch_en pulses, err=1 once, done never; IDLE after.
//   6 rst_n=0 during SETTLE -> latch_en/done/err 0, req_ready=1; then req 8'h55 completes with done.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and JK excitation encoding for the latch-bank write controller.
package jk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        PULSE   = 3'd2,
        SETTLE  = 3'd3,
        VERIFY  = 3'd4
    } jk_state_e;

    // {J,K} encodings; 2'b11 (toggle) is never produced.
    localparam logic [1:0] JK_HOLD  = 2'b00;
    localparam logic [1:0] JK_RESET = 2'b01;
    localparam logic [1:0] JK_SET   = 2'b10;

    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        if (q == t) begin
            return JK_HOLD;
        end else if (t) begin
            return JK_SET;
        end else begin
            return JK_RESET;
        end
    endfunction

endpackage

// File: rtl/jk_sync2.sv
// Two-flop synchronizer for the latch-bank readback bus.
module jk_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jk_latch_writer.sv
// Write-side controller for a JK latch bank: excite, pulse enable, settle, verify, retry.
module jk_latch_writer
    import jk_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             latch_en,
    output logic             done,
    output logic             err,
    output jk_state_e        state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and the requester holds req_data until then.

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 3);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES + 1);

    logic [WIDTH-1:0] qs;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] tgt_sel;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic [RW-1:0]    retry;
    logic [SW-1:0]    settle_cnt;

    jk_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_in),
        .q     (qs)
    );

    // Excitation is loaded on the edge entering COMPUTE so it is stable a cycle before the pulse.
    always_comb begin
        tgt_sel = (state == IDLE) ? req_data : target;
        j_next  = '0;
        k_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_next[i], k_next[i]} = jk_excite(qs[i], tgt_sel[i]);
        end
    end

    // The readback verdict is registered on the edge leaving SETTLE (or COMPUTE),
    // so VERIFY is the cycle in which done/err is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            retry      <= '0;
            settle_cnt <= '0;
            j_out      <= '0;
            k_out      <= '0;
            latch_en   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            latch_en <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        target    <= req_data;
                        retry     <= '0;
                        j_out     <= j_next;
                        k_out     <= k_next;
                        req_ready <= 1'b0;
                        state     <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (qs == target) begin
                        j_out <= '0;
                        k_out <= '0;
                        done  <= 1'b1;
                        state <= VERIFY;
                    end else begin
                        latch_en <= 1'b1;
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    j_out      <= '0;
                    k_out      <= '0;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        if (qs == target) begin
                            done  <= 1'b1;
                            state <= VERIFY;
                        end else if (retry == RETRY_MAX) begin
                            err   <= 1'b1;
                            state <= VERIFY;
                        end else begin
                            retry <= retry + 1'b1;
                            j_out <= j_next;
                            k_out <= k_next;
                            state <= COMPUTE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_latch_writer.sv
// Bench for jk_latch_writer: behavioural JK latch bank, directed requests, queued expected responses.
module tb_jk_latch_writer;
    import jk_pkg::*;

    localparam int W  = 8;
    localparam int EW = 22; // {done, err, latency[7:0], pulses[3:0], q[7:0]}

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_data;
    logic [W-1:0] q_in;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         latch_en;
    logic         done;
    logic         err;
    jk_state_e    state;

    jk_latch_writer #(.WIDTH(W), .SETTLE_CYCLES(2), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .q_in      (q_in),
        .j_out     (j_out),
        .k_out     (k_out),
        .latch_en  (latch_en),
        .done      (done),
        .err       (err),
        .state     (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- latch bank model ----------------
    logic [W-1:0] bank_q;
    logic [W-1:0] stuck0;
    logic [W-1:0] preset_val;
    int           preset_cnt;
    int           seen_cnt;

    initial begin
        bank_q   = '0;
        seen_cnt = 0;
    end

    always @(latch_en or j_out or k_out or preset_cnt) begin
        if (preset_cnt != seen_cnt) begin
            bank_q   = preset_val;
            seen_cnt = preset_cnt;
        end else if (latch_en) begin
            for (int i = 0; i < W; i++) begin
                if (j_out[i]) bank_q[i] = 1'b1;
                else if (k_out[i]) bank_q[i] = 1'b0;
            end
        end
    end

    assign q_in = bank_q & ~stuck0;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            checks;
    int            fails;
    int            viol;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic         xfer;
    logic         tracking;
    logic         prev_en;
    int           lat;
    int           pulses;
    logic [W-1:0] j_log[0:63];
    logic [W-1:0] k_log[0:63];
    logic         en_log[0:63];
    logic [EW-1:0] e;

    initial begin
        tracking = 1'b0;
        prev_en  = 1'b0;
        lat      = 0;
        pulses   = 0;
    end

    always @(posedge clk) begin
        xfer = req_valid && req_ready && rst_n;
        #1;
        if (!rst_n) begin
            tracking = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (xfer) begin
                tracking = 1'b1;
                lat      = 0;
                pulses   = 0;
                for (int i = 0; i < 64; i++) begin
                    j_log[i]  = '0;
                    k_log[i]  = '0;
                    en_log[i] = 1'b0;
                end
            end
            if (tracking) begin
                lat++;
                if (lat < 64) begin
                    j_log[lat]  = j_out;
                    k_log[lat]  = k_out;
                    en_log[lat] = latch_en;
                end
                if (latch_en) pulses++;
            end
            if ((j_out & k_out) != '0) viol++;
            if (latch_en && prev_en) viol++;
            if (done && err) viol++;
            prev_en = latch_en;
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'(done), 32'(err) ^ 32'(done) ^ 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_done",    32'(done),   32'(e[21]));
                    check("resp_err",     32'(err),    32'(e[20]));
                    check("resp_latency", 32'(lat),    32'(e[19:12]));
                    check("resp_pulses",  32'(pulses), 32'(e[11:8]));
                    check("resp_bank_q",  32'(q_in),   32'(e[7:0]));
                end
                tracking = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preset(input logic [W-1:0] v);
        preset_val = v;
        preset_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic issue(input logic [W-1:0] d);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tracking && n < 50);
        req_valid = 1'b0;
        if (!tracking) check("transfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic e_done, input logic e_err,
                        input logic [7:0] e_lat, input logic [3:0] e_pulses, input logic [W-1:0] e_q);
        int n;
        exp_q.push_back({e_done, e_err, e_lat, e_pulses, e_q});
        issue(d);
        n = 0;
        while (tracking && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tracking) check("response_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("idle_after_resp", 32'({req_ready, state}), 32'({1'b1, IDLE}));
    endtask

    // Directed table: bank start value, request, expected J/K in cycle 1, expected latency, pulses.
    typedef struct packed {
        logic [W-1:0] init;
        logic [W-1:0] req;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic [7:0]   elat;
        logic [3:0]   epulse;
    } vec_t;

    vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        checks     = 0;
        fails      = 0;
        viol       = 0;
        preset_cnt = 0;
        preset_val = '0;
        stuck0     = '0;
        req_valid  = 1'b0;
        req_data   = '0;
        rst_n      = 1'b0;

        vecs[0] = '{init: 8'h00, req: 8'hA5, ej: 8'hA5, ek: 8'h00, elat: 8'd7, epulse: 4'd1};
        vecs[1] = '{init: 8'hF0, req: 8'h0F, ej: 8'h0F, ek: 8'hF0, elat: 8'd7, epulse: 4'd1};
        vecs[2] = '{init: 8'h3C, req: 8'h3C, ej: 8'h00, ek: 8'h00, elat: 8'd2, epulse: 4'd0};
        vecs[3] = '{init: 8'h96, req: 8'h69, ej: 8'h69, ek: 8'h96, elat: 8'd7, epulse: 4'd1};
        vecs[4] = '{init: 8'hFF, req: 8'h00, ej: 8'h00, ek: 8'hFF, elat: 8'd7, epulse: 4'd1};

        // Reset state; bank contents untouched by reset
        preset(8'h5A);
        check("rst_j_out",     32'(j_out),     32'd0);
        check("rst_k_out",     32'(k_out),     32'd0);
        check("rst_latch_en",  32'(latch_en),  32'd0);
        check("rst_done_err",  32'({done, err}), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bank_kept", 32'(q_in), 32'h5A);

        foreach (vecs[v]) begin
            preset(vecs[v].init);
            send(vecs[v].req, 1'b1, 1'b0, vecs[v].elat, vecs[v].epulse, vecs[v].req);
            check("j_cycle1",  32'(j_log[1]),  32'(vecs[v].ej));
            check("k_cycle1",  32'(k_log[1]),  32'(vecs[v].ek));
            check("en_cycle1", 32'(en_log[1]), 32'd0);
            check("en_cycle2", 32'(en_log[2]), 32'(vecs[v].epulse != 0));
            check("en_cycle3", 32'(en_log[3]), 32'd0);
            if (vecs[v].epulse != 0) begin
                check("j_cycle2", 32'(j_log[2]), 32'(vecs[v].ej));
                check("k_cycle2", 32'(k_log[2]), 32'(vecs[v].ek));
            end
        end

        // Bit 0 stuck at 0: one pulse plus three retries, then err
        stuck0 = 8'h01;
        preset(8'h00);
        send(8'h01, 1'b0, 1'b1, 8'd25, 4'd4, 8'h00);
        stuck0 = 8'h00;

        // Reset in the middle of SETTLE aborts without a response
        preset(8'h00);
        issue(8'h0F);
        begin
            int n;
            n = 0;
            while (lat < 4 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("abort_in_settle", 32'(state), 32'(SETTLE));
        rst_n = 1'b0;
        #1;
        check("abort_latch_en",  32'(latch_en),  32'd0);
        check("abort_done_err",  32'({done, err}), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_state",     32'(state),     32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_bank_q", 32'(q_in), 32'h0F);
        send(8'h55, 1'b1, 1'b0, 8'd7, 4'd1, 8'h55);

        repeat (5) @(negedge clk);
        check("invariants", 32'(viol), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
